// File: rtl/mini_alu_pkg.sv
// Shared types for the mini ALU: opcodes, controller states and the flag bundle.
package mini_alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SHL = 3'b101,
      OP_SHR = 3'b110,
      OP_MUL = 3'b111
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic zero;
      logic carry;
      logic negative;
      logic overflow;
   } flags_t;

endpackage

// File: rtl/mini_alu_mul.sv
// Shift-add multiplier: one partial product per cycle over WIDTH cycles.
// done and product are valid together in the last iteration cycle.
module mini_alu_mul #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [2*WIDTH-1:0] acc_reg;
   logic [2*WIDTH-1:0] mcand_reg;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   mplier_reg;
   logic [CW-1:0]      count_reg;
   logic               run_reg;

   assign acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

   // Final accumulation is exposed combinationally so the caller can
   // register it on the same edge the last iteration completes.
   assign done    = run_reg && (count_reg == CW'(1));
   assign product = acc_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_reg    <= '0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         count_reg  <= '0;
         run_reg    <= 1'b0;
      end else if (start) begin
         acc_reg    <= '0;
         mcand_reg  <= {{WIDTH{1'b0}}, a};
         mplier_reg <= b;
         count_reg  <= CW'(WIDTH);
         run_reg    <= 1'b1;
      end else if (run_reg) begin
         acc_reg    <= acc_next;
         mcand_reg  <= mcand_reg << 1;
         mplier_reg <= mplier_reg >> 1;
         count_reg  <= count_reg - CW'(1);
         if (count_reg == CW'(1)) begin
            run_reg <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/mini_alu_core.sv
// Handshaked ALU with registered result/flags; define MINI_ALU_MUL_EN to
// enable the multi-cycle multiplier on op 111 (otherwise op 111 is illegal).
module mini_alu_core
   import mini_alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             negative,
   output logic             overflow,
   output logic             illegal,
   output logic             busy
);

`ifdef MINI_ALU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] result_reg, result_next;
   flags_t           flags_reg, flags_next;
   logic             illegal_reg, illegal_next;

   logic             accept;
   logic             is_mul;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] shl_val;
   logic [WIDTH-1:0] shr_val;
   logic [WIDTH-1:0] alu_result;
   logic             alu_carry;
   logic             alu_ovf;
   logic             alu_illegal;

   logic               mul_done;
   logic [2*WIDTH-1:0] mul_product;
   logic               mul_hi_nz;

   assign in_ready = !reset && ((state_reg == ST_IDLE) ||
                                ((state_reg == ST_DONE) && out_ready));
   assign accept   = in_valid && in_ready;
   assign is_mul   = MUL_EN && (op == OP_MUL);

   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_shift
         if (gi == 0) begin : g_lsb
            assign shl_val[gi] = 1'b0;
         end else begin : g_lsb_n
            assign shl_val[gi] = a[gi-1];
         end
         if (gi == WIDTH-1) begin : g_msb
            assign shr_val[gi] = 1'b0;
         end else begin : g_msb_n
            assign shr_val[gi] = a[gi+1];
         end
      end
   endgenerate

   always_comb begin
      alu_result  = '0;
      alu_carry   = 1'b0;
      alu_ovf     = 1'b0;
      alu_illegal = 1'b0;
      case (op)
         OP_ADD: begin
            alu_result = sum[WIDTH-1:0];
            alu_carry  = sum[WIDTH];
            alu_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            // diff[WIDTH] is the borrow out, i.e. a < b unsigned
            alu_result = diff[WIDTH-1:0];
            alu_carry  = diff[WIDTH];
            alu_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: alu_result = a & b;
         OP_OR:  alu_result = a | b;
         OP_XOR: alu_result = a ^ b;
         OP_SHL: begin
            alu_result = shl_val;
            alu_carry  = a[WIDTH-1];
         end
         OP_SHR: begin
            alu_result = shr_val;
            alu_carry  = a[0];
         end
         default: alu_illegal = !MUL_EN;
      endcase
   end

`ifdef MINI_ALU_MUL_EN
   mini_alu_mul #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (accept && is_mul),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (mul_product)
   );
   assign busy = (state_reg == ST_EXEC);
`else
   assign mul_done    = 1'b0;
   assign mul_product = '0;
   assign busy        = 1'b0;
`endif

   assign mul_hi_nz = |mul_product[2*WIDTH-1:WIDTH];

   always_comb begin
      state_next   = state_reg;
      result_next  = result_reg;
      flags_next   = flags_reg;
      illegal_next = illegal_reg;
      case (state_reg)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               if (is_mul) begin
                  state_next = ST_EXEC;
               end else begin
                  state_next          = ST_DONE;
                  result_next         = alu_result;
                  // an illegal op reports all flags clear, including zero
                  flags_next.zero     = (alu_result == '0) && !alu_illegal;
                  flags_next.carry    = alu_carry;
                  flags_next.negative = alu_result[WIDTH-1];
                  flags_next.overflow = alu_ovf;
                  illegal_next        = alu_illegal;
               end
            end else if ((state_reg == ST_DONE) && out_ready) begin
               state_next = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (mul_done) begin
               state_next          = ST_DONE;
               result_next         = mul_product[WIDTH-1:0];
               flags_next.zero     = (mul_product[WIDTH-1:0] == '0);
               flags_next.carry    = mul_hi_nz;
               flags_next.negative = mul_product[WIDTH-1];
               flags_next.overflow = mul_hi_nz;
               illegal_next        = 1'b0;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         result_reg  <= '0;
         flags_reg   <= '0;
         illegal_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         result_reg  <= result_next;
         flags_reg   <= flags_next;
         illegal_reg <= illegal_next;
      end
   end

   assign out_valid = (state_reg == ST_DONE);
   assign result    = result_reg;
   assign zero      = flags_reg.zero;
   assign carry     = flags_reg.carry;
   assign negative  = flags_reg.negative;
   assign overflow  = flags_reg.overflow;
   assign illegal   = illegal_reg;

endmodule

// File: tb/tb_mini_alu_core.sv
// Directed-vector bench for mini_alu_core at WIDTH=8; MUL checks follow MINI_ALU_MUL_EN.
module tb_mini_alu_core;
   import mini_alu_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic [2:0] op;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic       zero, carry, negative, overflow;
   logic       illegal;
   logic       busy;

   int tests_run    = 0;
   int tests_failed = 0;

   mini_alu_core #(.WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .carry     (carry),
      .negative  (negative),
      .overflow  (overflow),
      .illegal   (illegal),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("[TB] ok %s = 0x%0h", tag, got);
      end
   endtask

   // flags are compared as {zero, carry, negative, overflow}
   task automatic check_out(input string tag, input logic [7:0] er, input logic [3:0] ef,
                            input logic ei);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_result"}, 32'(result), 32'(er));
      check({tag, "_flags"}, 32'({zero, carry, negative, overflow}), 32'(ef));
      check({tag, "_illegal"}, 32'(illegal), 32'(ei));
   endtask

   // Called just after a rising edge; returns just after the handshake edge.
   task automatic do_op(input string tag, input logic [2:0] o, input logic [7:0] aa,
                        input logic [7:0] bb, input logic [7:0] er, input logic [3:0] ef,
                        input logic ei);
      in_valid = 1'b1;
      op = o;
      a  = aa;
      b  = bb;
      #1;
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = ~aa;
      b = ~bb;
      check_out(tag, er, ef, ei);
   endtask

`ifdef MINI_ALU_MUL_EN
   task automatic do_mul(input string tag, input logic [7:0] aa, input logic [7:0] bb,
                         input logic [7:0] er, input logic [3:0] ef);
      int cyc;
      in_valid = 1'b1;
      op = OP_MUL;
      a  = aa;
      b  = bb;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 8'h00;
      b = 8'h00;
      cyc = 1;
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
      while (!out_valid && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check({tag, "_latency"}, 32'(cyc), 32'd9);
      check({tag, "_busy_done"}, 32'(busy), 32'd0);
      check_out(tag, er, ef, 1'b0);
   endtask
`endif

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a  = '0;
      b  = '0;
      op = OP_ADD;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      reset = 1'b0;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_flags", 32'({zero, carry, negative, overflow}), 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);

      // ops issued on consecutive cycles; each result pops on the next edge
      do_op("add_10_5",   OP_ADD, 8'd10,  8'd5,   8'd15,  4'b0000, 1'b0);
      do_op("sub_5_5",    OP_SUB, 8'd5,   8'd5,   8'd0,   4'b1000, 1'b0);
      do_op("sub_3_5",    OP_SUB, 8'd3,   8'd5,   8'd254, 4'b0110, 1'b0);
      do_op("add_200_100",OP_ADD, 8'd200, 8'd100, 8'd44,  4'b0100, 1'b0);
      do_op("add_100_50", OP_ADD, 8'd100, 8'd50,  8'd150, 4'b0011, 1'b0);
      do_op("xor",        OP_XOR, 8'hF0,  8'hFF,  8'h0F,  4'b0000, 1'b0);
      do_op("or_zero",    OP_OR,  8'h00,  8'h00,  8'h00,  4'b1000, 1'b0);
      do_op("shr1",       OP_SHR, 8'h81,  8'hFF,  8'h40,  4'b0100, 1'b0);
      do_op("add_1_2",    OP_ADD, 8'd1,   8'd2,   8'd3,   4'b0000, 1'b0);
      do_op("and",        OP_AND, 8'h0F,  8'h3C,  8'h0C,  4'b0000, 1'b0);
      do_op("shl1",       OP_SHL, 8'h81,  8'h00,  8'h02,  4'b0100, 1'b0);
      @(posedge clk);
      #1;
      check("drain_out_valid", 32'(out_valid), 32'd0);

      // backpressure: hold ADD 1+1 for three cycles while inputs wander
      out_ready = 1'b0;
      do_op("bp_add", OP_ADD, 8'd1, 8'd1, 8'd2, 4'b0000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         a  = 8'(i * 37 + 5);
         op = OP_XOR;
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_hold_result", 32'(result), 32'd2);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         @(posedge clk);
         #1;
      end
      check("bp_still_result", 32'(result), 32'd2);
      out_ready = 1'b1;
      #1;
      check("bp_release_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      check("bp_release_valid", 32'(out_valid), 32'd0);

`ifdef MINI_ALU_MUL_EN
      do_mul("mul_12_11", 8'd12, 8'd11, 8'd132, 4'b0010);
      do_mul("mul_20_20", 8'd20, 8'd20, 8'd144, 4'b0111);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      op = OP_MUL;
      a  = 8'd7;
      b  = 8'd9;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("mulrst_busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("mulrst_out_valid", 32'(out_valid), 32'd0);
      check("mulrst_busy", 32'(busy), 32'd0);
      check("mulrst_in_ready", 32'(in_ready), 32'd0);
      reset = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check("mulrst_no_output", 32'(out_valid), 32'd0);
`else
      do_op("mul_off", OP_MUL, 8'd12, 8'd11, 8'd0, 4'b0000, 1'b1);
      check("mul_off_busy", 32'(busy), 32'd0);
      do_op("add_after_ill", OP_ADD, 8'd2, 8'd3, 8'd5, 4'b0000, 1'b0);
      @(posedge clk);
      #1;
`endif

      // reset while a result is held under backpressure
      out_ready = 1'b0;
      do_op("rstdone_add", OP_ADD, 8'd7, 8'd7, 8'd14, 4'b0000, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("rstdone_valid", 32'(out_valid), 32'd0);
      check("rstdone_result", 32'(result), 32'd0);
      reset = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mini_alu_core.md
# mini_alu_core

Parametrised, handshaked successor to the team's registered 8-bit ALU block. It accepts one operation per transfer on a valid/ready input channel and computes add, subtract, logic or shift in one cycle. It presents a registered result with zero/carry/negative/overflow flags on a valid/ready output channel. It sits between the instruction decode stage and the register writeback of the mini CPU and adds an optional multi-cycle shift-add multiplier.

## Interface
- WIDTH, 8: operand/result width in bits; legal range 4..32.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request present.
- in_ready  output  1  block can accept a request this cycle.
- a  input  WIDTH  operand A (unsigned, or two's complement for overflow).
- b  input  WIDTH  operand B.
- op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL1, 110 SHR1, 111 MUL.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer takes the result this cycle.
- result  output  WIDTH  registered result.
- zero, carry, negative, overflow  output  1 each  registered flags.
- illegal  output  1  registered; set with the result of an unsupported op.
- busy  output  1  high while in EXEC (multiply in progress).

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE: in_ready=1. On in_valid, latch operands. For a non-MUL op, go to DONE with the result registered. For MUL, go to EXEC.
- EXEC: shift-add over WIDTH cycles using a down-counter of $clog2(WIDTH)+1 bits. Then go to DONE. in_ready=0 and busy=1.
- DONE: out_valid=1. result and flags are held stable until out_ready.
- DONE with out_ready: the transfer completes. in_ready=out_ready in DONE, so a new request can be accepted in the same cycle and throughput is one single-cycle op per cycle.
- DONE with out_ready but no in_valid: go to IDLE.
- Arithmetic, WIDTH+1-bit internal sum:
  - ADD: carry = carry-out.
  - SUB: carry = borrow (a < b unsigned).
  - overflow (ADD/SUB only) = signed overflow.
- SHL1: carry = a[WIDTH-1]. SHR1 is logical; carry = a[0]. b is ignored for both.
- AND/OR/XOR: carry=0, overflow=0.
- MUL: result = low WIDTH bits of the 2*WIDTH product. carry = overflow = (high half != 0).
- All ops: zero = (result==0); negative = result[WIDTH-1]; illegal=0 unless stated otherwise.

## Timing
- Reset sets state=IDLE, out_valid=0, result=0, all flags=0, illegal=0, busy=0.
- in_ready is forced to 0 while reset is high.
- Reset in any state, including mid-EXEC, aborts the operation with no output transfer.
- Latency from the input handshake to out_valid:
  - 1 cycle for single-cycle ops.
  - WIDTH+1 cycles for MUL.
- Backpressure: while out_valid=1 and out_ready=0, the output registers and state are frozen and in_ready=0.
- The input is sampled only on the in_valid & in_ready cycle. Changes to a, b and op at other times have no effect.

## Configuration
- MINI_ALU_MUL_EN defined: op 111 is the multi-cycle multiplier and the EXEC state exists.
- MINI_ALU_MUL_EN undefined: the multiplier and EXEC logic are removed. op 111 completes in 1 cycle with result=0, all four flags=0 and illegal=1. busy is tied to 0.

## Structure
- Shared package mini_alu_pkg holds:
  - the op_t enum (3-bit opcodes above),
  - the state_t enum (IDLE/EXEC/DONE),
  - the flag bundle struct {zero, carry, negative, overflow}.
- Natural sub-module: mini_alu_mul, a shift-add multiplier with start/done.
  - It is instantiated only under MINI_ALU_MUL_EN and is parametrised by WIDTH.
  - Combinational op decoding stays in mini_alu_core.

## Test plan
All scenarios use WIDTH=8 and out_ready=1 unless stated otherwise.
- ADD a=10, b=5 -> one cycle later out_valid=1, result=15, all flags 0.
- SUB a=5, b=5 -> result=0, zero=1, carry=0. SUB a=3, b=5 -> result=254, carry=1, negative=1.
- ADD a=200, b=100 -> result=44, carry=1, overflow=0. ADD a=100, b=50 -> result=150, overflow=1, negative=1.
- Back-to-back ADD, AND(0x0F & 0x3C = 0x0C), SHL1(0x81 -> 0x02, carry=1) on consecutive cycles -> three results on three consecutive cycles.
- out_ready low for 3 cycles after ADD 1+1 -> result=2 held, in_ready=0, then released.
- MUL (macro on) 12*11 -> busy for 8 cycles, result=132 at handshake+9, carry=0. 20*20 -> result=144, carry=1, overflow=1.
- Reset mid-MUL -> next cycle state IDLE, out_valid=0, busy=0.
- MUL with macro off -> result=0, illegal=1 after 1 cycle.
